// File: rtl/memory_dp_param.sv
// Dual-port byte-enabled RAM: zero fill after reset, per-byte write-collision merge,
// out-of-range strobes and a 1- or 2-stage aligned read pipeline.
module memory_dp_param #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 2048,
  parameter int READ_LAT       = 1,
  parameter int WRITE_MODE     = 0,
  parameter int PRIO_B         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [31:0]         addr_a,
  input  logic [DATA_W-1:0]   data_i_a,
  input  logic [DATA_W/8-1:0] data_en_a,
  input  logic                write_en_a,
  output logic [DATA_W-1:0]   data_o_a,
  output logic                valid_o_a,
  output logic                err_a,
  input  logic [31:0]         addr_b,
  input  logic [DATA_W-1:0]   data_i_b,
  input  logic [DATA_W/8-1:0] data_en_b,
  input  logic                write_en_b,
  output logic [DATA_W-1:0]   data_o_b,
  output logic                valid_o_b,
  output logic                err_b
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q;
  logic [IW-1:0]     cnt_q;
  logic              ready_q;

  logic [IW-1:0]     idx_a, idx_b;
  logic              oor_a, oor_b, acc_a, acc_b, wr_a, wr_b, same_w;
  logic [DATA_W-1:0] post_a, post_b, dat_a_d, dat_b_d;

  logic              vld_a_p0_q, vld_b_p0_q, err_a_p0_q, err_b_p0_q;
  logic [DATA_W-1:0] dat_a_p0_q, dat_b_p0_q;

  function automatic logic [DATA_W-1:0] byte_mask(input logic [NB-1:0] en);
    for (int i = 0; i < NB; i++) byte_mask[8*i +: 8] = {8{en[i]}};
  endfunction

  // Word as stored after this edge, seen from one port, when the other port may win shared bytes.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] own,
                                               input logic [DATA_W-1:0] other,
                                               input logic [NB-1:0]     other_en,
                                               input logic              other_wins);
    merge = own;
    for (int i = 0; i < NB; i++)
      if (other_wins && other_en[i]) merge[8*i +: 8] = other[8*i +: 8];
  endfunction

  assign idx_a  = addr_a[OFF +: IW];
  assign idx_b  = addr_b[OFF +: IW];
  assign oor_a  = (addr_a >> (OFF + IW)) != 32'd0;
  assign oor_b  = (addr_b >> (OFF + IW)) != 32'd0;
  assign acc_a  = ready_q && (data_en_a != '0);
  assign acc_b  = ready_q && (data_en_b != '0);
  assign wr_a   = acc_a && write_en_a && !oor_a;
  assign wr_b   = acc_b && write_en_b && !oor_b;
  assign same_w = wr_a && wr_b && (idx_a == idx_b);
  assign post_a = merge(data_i_a, data_i_b, data_en_b, same_w && (PRIO_B != 0));
  assign post_b = merge(data_i_b, data_i_a, data_en_a, same_w && (PRIO_B == 0));

  always_comb begin
    dat_a_d = '0;
    dat_b_d = '0;
    if (!oor_a) dat_a_d = ((wr_a && WRITE_MODE != 0) ? post_a : mem[idx_a]) & byte_mask(data_en_a);
    if (!oor_b) dat_b_d = ((wr_b && WRITE_MODE != 0) ? post_b : mem[idx_b]) & byte_mask(data_en_b);
  end

  // The higher-priority port is written last so its bytes override on a shared word.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[cnt_q] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (PRIO_B != 0) begin
        if (wr_a && data_en_a[i]) mem[idx_a][8*i +: 8] <= data_i_a[8*i +: 8];
        if (wr_b && data_en_b[i]) mem[idx_b][8*i +: 8] <= data_i_b[8*i +: 8];
      end else begin
        if (wr_b && data_en_b[i]) mem[idx_b][8*i +: 8] <= data_i_b[8*i +: 8];
        if (wr_a && data_en_a[i]) mem[idx_a][8*i +: 8] <= data_i_a[8*i +: 8];
      end
    end
  end

  // Stage p0: control FSM and first read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      vld_a_p0_q <= 1'b0;
      vld_b_p0_q <= 1'b0;
      err_a_p0_q <= 1'b0;
      err_b_p0_q <= 1'b0;
      dat_a_p0_q <= '0;
      dat_b_p0_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + IW'(1);
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ready_q <= 1'b1;
        default: state_q <= INIT;
      endcase
      vld_a_p0_q <= acc_a;
      vld_b_p0_q <= acc_b;
      err_a_p0_q <= acc_a && oor_a;
      err_b_p0_q <= acc_b && oor_b;
      if (acc_a) dat_a_p0_q <= dat_a_d;
      if (acc_b) dat_b_p0_q <= dat_b_d;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              vld_a_p1_q, vld_b_p1_q, err_a_p1_q, err_b_p1_q;
      logic [DATA_W-1:0] dat_a_p1_q, dat_b_p1_q;
      // Stage p1: extra output register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_a_p1_q <= 1'b0;
          vld_b_p1_q <= 1'b0;
          err_a_p1_q <= 1'b0;
          err_b_p1_q <= 1'b0;
          dat_a_p1_q <= '0;
          dat_b_p1_q <= '0;
        end else begin
          vld_a_p1_q <= vld_a_p0_q;
          vld_b_p1_q <= vld_b_p0_q;
          err_a_p1_q <= err_a_p0_q;
          err_b_p1_q <= err_b_p0_q;
          if (vld_a_p0_q) dat_a_p1_q <= dat_a_p0_q;
          if (vld_b_p0_q) dat_b_p1_q <= dat_b_p0_q;
        end
      end
      assign data_o_a  = dat_a_p1_q;
      assign data_o_b  = dat_b_p1_q;
      assign valid_o_a = vld_a_p1_q;
      assign valid_o_b = vld_b_p1_q;
      assign err_a     = err_a_p1_q;
      assign err_b     = err_b_p1_q;
    end else begin : g_lat1
      assign data_o_a  = dat_a_p0_q;
      assign data_o_b  = dat_b_p0_q;
      assign valid_o_a = vld_a_p0_q;
      assign valid_o_b = vld_b_p0_q;
      assign err_a     = err_a_p0_q;
      assign err_b     = err_b_p0_q;
    end
  endgenerate

  assign ready = ready_q;
endmodule

// File: tb/tb_memory_dp_param.sv
// Bench for memory_dp_param: two configurations driven with identical stimulus and
// compared every cycle against a word-array reference model, plus directed vectors.
`timescale 1ns/1ps
module tb_memory_dp_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr_a, data_i_a, addr_b, data_i_b;
  logic [3:0]  data_en_a, data_en_b;
  logic        write_en_a, write_en_b;
  logic [1:0]        ready, valid_o_a, valid_o_b, err_a, err_b;
  logic [1:0][31:0]  data_o_a, data_o_b;

  int n_chk = 0;
  int n_err = 0;

  // dut0: defaults; dut1: small, two-cycle latency, write-first, port A priority
  memory_dp_param #(.DATA_W(32), .DEPTH(2048), .READ_LAT(1), .WRITE_MODE(0), .PRIO_B(1), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .ready(ready[0]),
    .addr_a(addr_a), .data_i_a(data_i_a), .data_en_a(data_en_a), .write_en_a(write_en_a),
    .data_o_a(data_o_a[0]), .valid_o_a(valid_o_a[0]), .err_a(err_a[0]),
    .addr_b(addr_b), .data_i_b(data_i_b), .data_en_b(data_en_b), .write_en_b(write_en_b),
    .data_o_b(data_o_b[0]), .valid_o_b(valid_o_b[0]), .err_b(err_b[0]));

  memory_dp_param #(.DATA_W(32), .DEPTH(64), .READ_LAT(2), .WRITE_MODE(1), .PRIO_B(0), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .ready(ready[1]),
    .addr_a(addr_a), .data_i_a(data_i_a), .data_en_a(data_en_a), .write_en_a(write_en_a),
    .data_o_a(data_o_a[1]), .valid_o_a(valid_o_a[1]), .err_a(err_a[1]),
    .addr_b(addr_b), .data_i_b(data_i_b), .data_en_b(data_en_b), .write_en_b(write_en_b),
    .data_o_b(data_o_b[1]), .valid_o_b(valid_o_b[1]), .err_b(err_b[1]));

  function automatic int dep(input int d);  return (d == 0) ? 2048 : 64; endfunction
  function automatic int lat(input int d);  return (d == 0) ? 1 : 2;     endfunction
  function automatic bit wmode(input int d); return d != 0;              endfunction
  function automatic bit prio_b(input int d); return d == 0;             endfunction

  function automatic logic [31:0] mask(input logic [3:0] en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{en[i]}};
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: word arrays, edges since reset, and a result schedule indexed by edge number
  logic [31:0] mm   [2][2048];
  int          fcnt [2];
  logic        sv   [2][2][4];
  logic        se   [2][2][4];
  logic [31:0] sd   [2][2][4];
  logic [31:0] last [2][2];
  int          ec = 0;

  task automatic model_clear(input int d);
    fcnt[d] = 0;
    for (int p = 0; p < 2; p++) begin
      last[d][p] = '0;
      for (int s = 0; s < 4; s++) begin
        sv[d][p][s] = 1'b0;
        se[d][p][s] = 1'b0;
        sd[d][p][s] = '0;
      end
    end
  endtask

  task automatic model_edge(input int d);
    logic [31:0] ad [2], di [2], old [2], res [2];
    logic [3:0]  en [2];
    logic        we [2], acc [2], oor [2], wr [2];
    int          w [2], first, slot, cur;
    ad = '{addr_a, addr_b};
    di = '{data_i_a, data_i_b};
    en = '{data_en_a, data_en_b};
    we = '{write_en_a, write_en_b};
    for (int p = 0; p < 2; p++) begin
      w[p]   = int'(ad[p] >> 2);
      oor[p] = (ad[p] >> 2) >= 32'(dep(d));
      acc[p] = (fcnt[d] >= dep(d)) && (en[p] != 4'h0);
      wr[p]  = acc[p] && we[p] && !oor[p];
      old[p] = oor[p] ? 32'h0 : mm[d][w[p]];
    end
    first = prio_b(d) ? 0 : 1;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? first : 1 - first;
      if (wr[p])
        for (int i = 0; i < 4; i++)
          if (en[p][i]) mm[d][w[p]][8*i +: 8] = di[p][8*i +: 8];
    end
    if (fcnt[d] < dep(d)) begin
      mm[d][fcnt[d]] = 32'h0;
      fcnt[d]++;
    end
    slot = (ec + lat(d) - 1) % 4;
    cur  = ec % 4;
    for (int p = 0; p < 2; p++) begin
      res[p] = oor[p] ? 32'h0 : (((wr[p] && wmode(d)) ? mm[d][w[p]] : old[p]) & mask(en[p]));
      sv[d][p][slot] = acc[p];
      se[d][p][slot] = acc[p] && oor[p];
      sd[d][p][slot] = res[p];
      if (sv[d][p][cur]) last[d][p] = sd[d][p][cur];
    end
  endtask

  always @(posedge clk) begin
    ec = ec + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) model_clear(d);
      else     model_edge(d);
    end
  end

  always @(negedge clk) begin
    int cur;
    cur = ec % 4;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d ready", d), 32'(ready[d]), 32'(fcnt[d] >= dep(d)));
      check($sformatf("dut%0d valid_a", d), 32'(valid_o_a[d]), 32'(sv[d][0][cur]));
      check($sformatf("dut%0d valid_b", d), 32'(valid_o_b[d]), 32'(sv[d][1][cur]));
      check($sformatf("dut%0d err_a", d), 32'(err_a[d]), 32'(se[d][0][cur]));
      check($sformatf("dut%0d err_b", d), 32'(err_b[d]), 32'(se[d][1][cur]));
      check($sformatf("dut%0d data_a", d), data_o_a[d], last[d][0]);
      check($sformatf("dut%0d data_b", d), data_o_b[d], last[d][1]);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic wa, input logic [31:0] aa, input logic [31:0] da, input logic [3:0] ea,
                       input logic wb, input logic [31:0] ab, input logic [31:0] db, input logic [3:0] eb);
    write_en_a = wa; addr_a = aa; data_i_a = da; data_en_a = ea;
    write_en_b = wb; addr_b = ab; data_i_b = db; data_en_b = eb;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_fill();
    int k, k1;
    k1 = 0;
    for (k = 1; k <= 2200; k++) begin
      step();
      if (ready[1] && k1 == 0) k1 = k;
      if (ready[0]) break;
    end
    check("dut0 fill cycles", 32'(k), 32'd2048);
    check("dut1 fill cycles", 32'(k1), 32'd64);
  endtask

  function automatic logic [31:0] raddr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'h2000 | 32'($urandom_range(0, 63));
    if (r == 1) return 32'h100 + 32'($urandom_range(0, 63) << 2);
    return 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
  endfunction

  typedef struct {
    logic wa; logic [31:0] aa; logic [31:0] da; logic [3:0] ea;
    logic wb; logic [31:0] ab; logic [31:0] db; logic [3:0] eb;
    logic [31:0] xa0; logic [31:0] xb0; logic [31:0] xa1; logic [31:0] xb1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    for (int d = 0; d < 2; d++) model_clear(d);
    tbl[0]  = '{1'b1, 32'h8,    32'haaaaaaaa, 4'hf, 1'b1, 32'h8,    32'hbbbbbbbb, 4'h3,
                32'h0, 32'h0, 32'haaaaaaaa, 32'h0000aaaa};
    tbl[1]  = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b0, 32'h0,    32'h0,        4'h0,
                32'haaaabbbb, 32'h0, 32'haaaaaaaa, 32'h0000aaaa};
    tbl[2]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 32'h2a0,  32'hffaaaaff, 4'h6,
                32'haaaabbbb, 32'h0, 32'haaaaaaaa, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h2a0,  32'h0,        4'hf,
                32'haaaabbbb, 32'h00aaaa00, 32'haaaaaaaa, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h2a0,  32'h0,        4'h4,
                32'haaaabbbb, 32'h00aa0000, 32'haaaaaaaa, 32'h0};
    tbl[5]  = '{1'b1, 32'h2000, 32'hdeadc0de, 4'hf, 1'b0, 32'h0,    32'h0,        4'h0,
                32'h0, 32'h00aa0000, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,    32'h0,        4'hf, 1'b0, 32'h0,    32'h0,        4'h0,
                32'h0, 32'h00aa0000, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 32'h10,   32'h12345678, 4'hf, 1'b1, 32'h14,   32'hcafef00d, 4'hf,
                32'h0, 32'h0, 32'h12345678, 32'hcafef00d};
    tbl[8]  = '{1'b0, 32'h11,   32'h0,        4'hf, 1'b0, 32'h14,   32'h0,        4'h2,
                32'h12345678, 32'h0000f000, 32'h12345678, 32'h0000f000};
    tbl[9]  = '{1'b1, 32'hc,    32'h11223344, 4'h9, 1'b0, 32'hc,    32'h0,        4'hf,
                32'h0, 32'h0, 32'h11000044, 32'h0};
    tbl[10] = '{1'b0, 32'hc,    32'h0,        4'hf, 1'b0, 32'h1ffc, 32'h0,        4'hf,
                32'h11000044, 32'h0, 32'h11000044, 32'h0};

    rst = 1'b1;
    idle();
    repeat (3) step();
    check("ready in reset", 32'(ready), 32'h0);
    rst = 1'b0;
    wait_fill();

    // Top word of the default depth reads back zero one cycle after the request
    drive(1'b0, 32'h1ffc, 32'h0, 4'hf, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    idle();
    check("top word valid", 32'(valid_o_a[0]), 32'h1);
    check("top word data", data_o_a[0], 32'h0);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].ea, tbl[i].wb, tbl[i].ab, tbl[i].db, tbl[i].eb);
      step();
      idle();
      step();
      check($sformatf("vec%0d dut0 a", i), data_o_a[0], tbl[i].xa0);
      check($sformatf("vec%0d dut0 b", i), data_o_b[0], tbl[i].xb0);
      check($sformatf("vec%0d dut1 a", i), data_o_a[1], tbl[i].xa1);
      check($sformatf("vec%0d dut1 b", i), data_o_b[1], tbl[i].xb1);
    end

    // Write then read the same word back-to-back
    drive(1'b1, 32'h20, 32'h12345678, 4'hf, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("b2b dut0 v1", 32'(valid_o_a[0]), 32'h1);
    check("b2b dut0 d1", data_o_a[0], 32'h0);
    check("b2b dut1 v1", 32'(valid_o_a[1]), 32'h0);
    drive(1'b0, 32'h20, 32'h0, 4'hf, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    idle();
    check("b2b dut0 d2", data_o_a[0], 32'h12345678);
    check("b2b dut1 v2", 32'(valid_o_a[1]), 32'h1);
    check("b2b dut1 d2", data_o_a[1], 32'h12345678);
    step();
    check("b2b dut0 v3", 32'(valid_o_a[0]), 32'h0);
    check("b2b dut1 v3", 32'(valid_o_a[1]), 32'h1);
    check("b2b dut1 d3", data_o_a[1], 32'h12345678);
    step();

    // Reset lands while a two-cycle read is in flight
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h18, 32'h5a5a5a5a, 4'hf);
    step();
    idle();
    step();
    drive(1'b0, 32'h18, 32'h0, 4'hf, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    rst = 1'b1;
    idle();
    step();
    check("rst dut1 valid", 32'(valid_o_a[1]), 32'h0);
    check("rst ready", 32'(ready), 32'h0);
    check("rst dut0 data", data_o_a[0], 32'h0);
    step();
    rst = 1'b0;
    wait_fill();
    drive(1'b0, 32'h18, 32'h0, 4'hf, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    idle();
    step();
    check("refill dut0 word", data_o_a[0], 32'h0);
    check("refill dut1 word", data_o_a[1], 32'h0);

    // Randomised traffic concentrated on a few words to provoke collisions
    for (int n = 0; n < 800; n++) begin
      drive(1'($urandom_range(0, 1)), raddr(), $urandom(), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), raddr(), $urandom(), 4'($urandom_range(0, 15)));
      step();
    end
    idle();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/memory_dp_param.md
Name: memory_dp_param

Overview:
Parametrised dual-port, byte-enabled synchronous RAM. It is the next-generation data/instruction memory for the core.
Improvements over the fixed 8 KiB memory:
- configurable width, depth and read latency
- hardware zero-fill after reset, with a ready flag
- per-byte collision merge between ports
- out-of-range error reporting
- read-valid strobes

It sits between the core's fetch port (A) and load/store port (B).

Parameters:
DATA_W, 32, word width in bits; multiple of 8, at least 8.
DEPTH, 2048, number of words; power of two (default 8 KiB at 32 bits).
READ_LAT, 1, read latency in clock edges; legal values 1 or 2.
WRITE_MODE, 0, same-port write return value; 0 = read-first (old word), 1 = write-first (merged new word).
PRIO_B, 1, on a same-word write collision, 1 = port B bytes win, 0 = port A bytes win.
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip the fill.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
ready  out  1  high once initialisation is complete; requests are accepted only while high.
addr_a  in  32  port A byte address; word index = addr_a[$clog2(DATA_W/8) +: $clog2(DEPTH)].
data_i_a  in  DATA_W  port A write data.
data_en_a  in  DATA_W/8  port A byte enables; all-zero = NOP.
write_en_a  in  1  port A: 1 = write, 0 = read.
data_o_a  out  DATA_W  port A read data.
valid_o_a  out  1  port A data_o_a valid strobe.
err_a  out  1  port A out-of-range strobe.
addr_b, data_i_b, data_en_b, write_en_b, data_o_b, valid_o_b, err_b: identical for port B.

Behaviour:
- Reset (async assert): ready=0, data_o_*=0, valid_o_*=0, err_*=0, pipeline registers cleared, FSM to INIT (or RUN if CLEAR_ON_RESET=0), fill counter=0.
- Memory contents are not changed by reset itself.
- FSM INIT:
  - Each edge writes all-zero to word[cnt], then cnt++.
  - After word DEPTH-1 is written, move to RUN; ready=1 from that edge.
  - Fill takes exactly DEPTH cycles after rst deasserts.
- FSM RUN: ready=1 until the next rst.
- With CLEAR_ON_RESET=0: first edge after rst deasserts enters RUN, ready=1; contents are undefined (X in simulation).
- Requests while ready=0 are ignored: no write, valid_o and err stay 0.
- Accepted access: ready=1 and data_en!=0, sampled at edge N.
  - Read result appears on data_o after edge N+READ_LAT-1.
  - valid_o is high for exactly that cycle.
- Read data: bytes with data_en=1 return stored bytes; bytes with data_en=0 are driven 0.
- NOP (data_en=0): data_o holds its last value, valid_o=0.
- Write: only enabled bytes are updated at edge N. valid_o is pulsed with the same latency as a read.
  - WRITE_MODE=0: data_o = pre-write word (masked).
  - WRITE_MODE=1: data_o = post-write merged word (masked).
- Cross-port read of a word being written by the other port in the same cycle returns the old data.
- Both ports write the same word in the same cycle:
  - Bytes enabled on both ports: the PRIO_B-selected port wins.
  - Bytes enabled on one port only: that port's data is written.
- Out-of-range address (any addr bit above the index field set):
  - Write suppressed; read data = 0.
  - err and valid_o pulse together with the normal latency.
- Unaligned addresses: low byte-offset bits are ignored.
- READ_LAT=2: one extra output register; valid/err/data stay aligned. Back-to-back requests every cycle are supported, with one result per cycle.
- rst asserted mid-operation: in-flight reads are dropped (no valid_o), FSM restarts INIT.

Test Plan:
1. Reset, CLEAR_ON_RESET=1, DEPTH=2048: ready rises exactly 2048 cycles after rst deasserts; a read of 0x1ffc then returns 0x00000000 with valid_o_a=1 one cycle later.
2. Collision: A writes 0x8 = 0xAAAAAAAA (en 1111) and B writes 0x8 = 0xBBBBBBBB (en 0011) in the same cycle; a later read of 0x8 returns 0xAAAABBBB with PRIO_B=1, 0xAAAAAAAA with PRIO_B=0.
3. Byte enables: B writes 0x2a0 = 0xffaaaaff with en 0110 over the zero-filled word; reading 0x2a0 with en 1111 returns 0x00aaaa00; reading with en 0100 returns 0x00aa0000.
4. Latency and mode: READ_LAT=2, WRITE_MODE=1, A writes 0x10 = 0x12345678 then reads 0x10 back-to-back; data_o_a = 0x12345678 with valid_o_a high on two consecutive cycles starting 2 edges after the write. With WRITE_MODE=0, the first result is 0x00000000.
5. Out of range: read 0x2000 (DEPTH=2048) gives err_a=1, valid_o_a=1, data_o_a=0; write 0x2000 = 0xdeadc0de leaves word 0 unchanged (read of 0x0 returns 0).
6. Reset mid-stream: assert rst one cycle after issuing a read with READ_LAT=2; no valid_o pulse occurs, ready=0, and the fill restarts from word 0.
